// File: rtl/grant_decoder_pkg.sv
// Shared types and elaboration-time parameter checks for grant_decoder.
// No logic; latency and backpressure live in the modules that import it.
// State encodings are fixed so waveforms and debug taps stay stable.
package grant_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    localparam int DEF_N_OUT  = 4;
    localparam int DEF_CODE_W = 2;
    localparam int DEF_HOLD   = 3;
    localparam int DEF_GAP    = 1;
    localparam int DEF_DROP_W = 8;

    function automatic bit cfg_ok(input int n_out, input int code_w,
                                  input int hold, input int gap, input int drop_w);
        return (n_out >= 2) && ((n_out & (n_out - 1)) == 0) &&
               (code_w == $clog2(n_out)) && (hold >= 1) && (gap >= 0) &&
               (drop_w >= 1);
    endfunction

    localparam bit DEF_CFG_OK = cfg_ok(DEF_N_OUT, DEF_CODE_W, DEF_HOLD, DEF_GAP, DEF_DROP_W);

    // Counter only ever holds HOLD-1 or GAP-1, so max(HOLD,GAP) values suffice.
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Binary index to one-hot decoder.
// Purely combinational, zero latency.
// No flow control; output follows code directly.
module onehot_dec
    import grant_decoder_pkg::*;
#(
    parameter int N_OUT  = DEF_N_OUT,
    parameter int CODE_W = DEF_CODE_W
) (
    input  logic [CODE_W-1:0] code,
    output logic [N_OUT-1:0]  onehot
);

    always_comb begin
        onehot       = '0;
        onehot[code] = 1'b1;
    end

endmodule

// File: rtl/grant_decoder.sv
// Turns an accepted (code, valid) into a one-hot grant held HOLD cycles, then GAP idle cycles.
// Grant appears one cycle after the accepting edge; outputs come from registers only.
// Refuses codes while busy (ready=0) and counts refused cycles in a saturating drop_cnt.
module grant_decoder
    import grant_decoder_pkg::*;
#(
    parameter int N_OUT  = DEF_N_OUT,
    parameter int CODE_W = DEF_CODE_W,
    parameter int HOLD   = DEF_HOLD,
    parameter int GAP    = DEF_GAP,
    parameter int DROP_W = DEF_DROP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              ready,
    output logic [N_OUT-1:0]  grant,
    output logic              grant_valid,
    output logic              done,
    output logic [DROP_W-1:0] drop_cnt
);

    if (!cfg_ok(N_OUT, CODE_W, HOLD, GAP, DROP_W)) begin : g_bad_cfg
        $error("grant_decoder: illegal parameter combination");
    end

    localparam int                CNT_W    = cnt_width(HOLD, GAP);
    localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] code_nxt;
    logic [N_OUT-1:0]  dec;
    logic              in_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            code_q   <= '0;
            drop_cnt <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            code_q <= code_nxt;
            if (code_valid && (state != ST_IDLE) && (drop_cnt != DROP_MAX)) begin
                drop_cnt <= drop_cnt + DROP_ONE;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        code_nxt  = code_q;
        case (state)
            ST_IDLE: begin
                if (code_valid) begin
                    state_nxt = ST_GRANT;
                    cnt_nxt   = HOLD_LD;
                    code_nxt  = code_in;
                end
            end
            ST_GRANT: begin
                if (cnt == '0) begin
                    if (GAP == 0) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = GAP_LD;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    onehot_dec #(
        .N_OUT  (N_OUT),
        .CODE_W (CODE_W)
    ) u_dec (
        .code   (code_q),
        .onehot (dec)
    );

    always_comb begin
        in_grant    = (state == ST_GRANT);
        ready       = (state == ST_IDLE);
        grant_valid = in_grant;
        done        = in_grant && (cnt == '0);
        grant       = in_grant ? dec : '0;
    end

endmodule

// File: tb/tb_grant_decoder.sv
// Bench for grant_decoder: vector table, hand sequences and random traffic vs a timeline model.
module tb_grant_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       code_valid = 1'b0;
    logic [1:0] code_in = 2'd0;

    logic       rdy0, gv0, dn0, rdy1, gv1, dn1;
    logic [3:0] g0, g1;
    logic [7:0] dc0, dc1;

    grant_decoder #(.N_OUT(4), .CODE_W(2), .HOLD(3), .GAP(1), .DROP_W(8)) u_dut (
        .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
        .ready(rdy0), .grant(g0), .grant_valid(gv0), .done(dn0), .drop_cnt(dc0));

    grant_decoder #(.N_OUT(4), .CODE_W(2), .HOLD(3), .GAP(0), .DROP_W(8)) u_gap0 (
        .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
        .ready(rdy1), .grant(g1), .grant_valid(gv1), .done(dn1), .drop_cnt(dc1));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a busy instance is "age" cycles past its accepting edge.
    int m_busy[2];
    int m_age[2];
    int m_code[2];
    int m_drop[2];

    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i);
        if (rst) begin
            m_busy[i] = 0;
            m_age[i]  = 0;
            m_drop[i] = 0;
        end else if (m_busy[i] != 0) begin
            if (code_valid && m_drop[i] < 255) m_drop[i]++;
            m_age[i]++;
            if (m_age[i] > 3 + gap_of(i)) m_busy[i] = 0;
        end else if (code_valid) begin
            m_busy[i] = 1;
            m_age[i]  = 1;
            m_code[i] = int'(code_in);
        end
    endtask

    task automatic model_check(input int i);
        logic [3:0] g;
        logic       gv, dn, rd;
        logic [7:0] dc;
        bit         ing;
        ing = (m_busy[i] != 0) && (m_age[i] <= 3);
        if (i == 0) begin
            g = g0; gv = gv0; dn = dn0; rd = rdy0; dc = dc0;
        end else begin
            g = g1; gv = gv1; dn = dn1; rd = rdy1; dc = dc1;
        end
        chk($sformatf("m%0d.grant", i), 32'(g), ing ? (32'd1 << m_code[i]) : 32'd0);
        chk($sformatf("m%0d.grant_valid", i), 32'(gv), 32'(ing));
        chk($sformatf("m%0d.done", i), 32'(dn), 32'(ing && m_age[i] == 3));
        chk($sformatf("m%0d.ready", i), 32'(rd), 32'(m_busy[i] == 0));
        chk($sformatf("m%0d.drop_cnt", i), 32'(dc), 32'(m_drop[i]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        model_check(0);
        model_check(1);
    endtask

    typedef struct {
        bit         rst;
        bit         vld;
        logic [1:0] code;
        logic [3:0] g;
        bit         gv;
        bit         dn;
        bit         rdy;
        logic [7:0] drop;
    } vec_t;

    vec_t tbl[$];

    initial begin
        m_busy = '{0, 0};
        m_age  = '{0, 0};
        m_code = '{0, 0};
        m_drop = '{0, 0};

        // Reset with a pending request
        tbl.push_back('{1, 1, 2'd3, 4'b0000, 0, 0, 1, 8'd0});
        tbl.push_back('{1, 1, 2'd3, 4'b0000, 0, 0, 1, 8'd0});
        tbl.push_back('{0, 0, 2'd3, 4'b0000, 0, 0, 1, 8'd0});
        // Single pulse, code 2
        tbl.push_back('{0, 1, 2'd2, 4'b0100, 1, 0, 0, 8'd0});
        tbl.push_back('{0, 0, 2'd2, 4'b0100, 1, 0, 0, 8'd0});
        tbl.push_back('{0, 0, 2'd2, 4'b0100, 1, 1, 0, 8'd0});
        tbl.push_back('{0, 0, 2'd2, 4'b0000, 0, 0, 0, 8'd0});
        tbl.push_back('{0, 0, 2'd2, 4'b0000, 0, 0, 1, 8'd0});
        // code_valid held, code 3: period 5, +4 drops per period
        tbl.push_back('{0, 1, 2'd3, 4'b1000, 1, 0, 0, 8'd0});
        tbl.push_back('{0, 1, 2'd3, 4'b1000, 1, 0, 0, 8'd1});
        tbl.push_back('{0, 1, 2'd3, 4'b1000, 1, 1, 0, 8'd2});
        tbl.push_back('{0, 1, 2'd3, 4'b0000, 0, 0, 0, 8'd3});
        tbl.push_back('{0, 1, 2'd3, 4'b0000, 0, 0, 1, 8'd4});
        tbl.push_back('{0, 1, 2'd3, 4'b1000, 1, 0, 0, 8'd4});
        tbl.push_back('{0, 1, 2'd3, 4'b1000, 1, 0, 0, 8'd5});
        tbl.push_back('{0, 1, 2'd3, 4'b1000, 1, 1, 0, 8'd6});
        tbl.push_back('{0, 1, 2'd3, 4'b0000, 0, 0, 0, 8'd7});
        tbl.push_back('{0, 1, 2'd3, 4'b0000, 0, 0, 1, 8'd8});
        tbl.push_back('{0, 1, 2'd3, 4'b1000, 1, 0, 0, 8'd8});
        // Code changes while busy are ignored
        tbl.push_back('{1, 0, 2'd0, 4'b0000, 0, 0, 1, 8'd0});
        tbl.push_back('{0, 1, 2'd0, 4'b0001, 1, 0, 0, 8'd0});
        tbl.push_back('{0, 1, 2'd1, 4'b0001, 1, 0, 0, 8'd1});
        tbl.push_back('{0, 1, 2'd1, 4'b0001, 1, 1, 0, 8'd2});
        tbl.push_back('{0, 1, 2'd1, 4'b0000, 0, 0, 0, 8'd3});
        tbl.push_back('{0, 1, 2'd1, 4'b0000, 0, 0, 1, 8'd4});
        tbl.push_back('{0, 1, 2'd1, 4'b0010, 1, 0, 0, 8'd4});
        // Reset mid-grant: no done, drop_cnt clears
        tbl.push_back('{1, 0, 2'd0, 4'b0000, 0, 0, 1, 8'd0});
        tbl.push_back('{0, 1, 2'd2, 4'b0100, 1, 0, 0, 8'd0});
        tbl.push_back('{0, 1, 2'd2, 4'b0100, 1, 0, 0, 8'd1});
        tbl.push_back('{1, 1, 2'd2, 4'b0000, 0, 0, 1, 8'd0});
        tbl.push_back('{0, 0, 2'd2, 4'b0000, 0, 0, 1, 8'd0});

        foreach (tbl[i]) begin
            rst        = tbl[i].rst;
            code_valid = tbl[i].vld;
            code_in    = tbl[i].code;
            tick();
            chk($sformatf("vec%0d.grant", i), 32'(g0), 32'(tbl[i].g));
            chk($sformatf("vec%0d.grant_valid", i), 32'(gv0), 32'(tbl[i].gv));
            chk($sformatf("vec%0d.done", i), 32'(dn0), 32'(tbl[i].dn));
            chk($sformatf("vec%0d.ready", i), 32'(rdy0), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d.drop_cnt", i), 32'(dc0), 32'(tbl[i].drop));
        end

        // GAP=0 instance: grant k+1..k+3, ready again at k+4
        rst = 1'b1; code_valid = 1'b0;
        tick();
        rst = 1'b0; code_valid = 1'b1; code_in = 2'd1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            code_valid = 1'b0;
            chk($sformatf("gap0.c%0d.grant", c), 32'(g1), (c <= 3) ? 32'd2 : 32'd0);
            chk($sformatf("gap0.c%0d.done", c), 32'(dn1), 32'(c == 3));
            chk($sformatf("gap0.c%0d.ready", c), 32'(rdy1), 32'(c == 4));
        end

        // Saturation: code_valid held for 400 cycles
        code_valid = 1'b1;
        for (int c = 0; c < 400; c++) begin
            code_in = 2'($urandom_range(0, 3));
            tick();
        end
        chk("sat.drop0", 32'(dc0), 32'd255);
        chk("sat.drop1", 32'(dc1), 32'd255);
        tick();
        chk("sat.hold0", 32'(dc0), 32'd255);

        // Random traffic with varying request density and occasional reset
        for (int seg = 0; seg < 20; seg++) begin
            int dens;
            dens = $urandom_range(0, 100);
            for (int c = 0; c < 100; c++) begin
                rst        = ($urandom_range(0, 59) == 0);
                code_valid = ($urandom_range(0, 99) < dens);
                code_in    = 2'($urandom_range(0, 3));
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/grant_decoder.md
Name: grant_decoder

Overview:
- Companion to the 4-input priority encoder. Takes its registered (code, valid) output and turns it back into a one-hot grant.
- Each accepted code produces a grant held for a fixed number of cycles, followed by an optional idle gap.
- While busy, the block refuses new codes and counts refused-request cycles. Sits between the encoder and the downstream requesters.

Parameters:
- N_OUT, 4, number of one-hot grant lines; must be a power of 2, at least 2.
- CODE_W, 2, code width; must equal clog2(N_OUT).
- HOLD, 3, grant duration in cycles; at least 1.
- GAP, 1, idle cycles after each grant before the next acceptance; at least 0.
- DROP_W, 8, width of the refused-request counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- code_in  in  CODE_W  index to grant; bit position in grant.
- code_valid  in  1  code_in is meaningful; level signal, may stay high for many cycles.
- ready  out  1  block is in IDLE and will accept on this edge.
- grant  out  N_OUT  one-hot grant; all zeros when idle.
- grant_valid  out  1  a grant is active.
- done  out  1  high during the final grant cycle.
- drop_cnt  out  DROP_W  saturating count of cycles with code_valid=1 and ready=0.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- All outputs are decoded from registers only; there is no combinational path from any input to any output.
- Reset values: state IDLE, grant 0, grant_valid 0, done 0, drop_cnt 0, hold/gap counter 0. ready is 1 in the first cycle after rst deasserts.
- FSM states:
  - IDLE:
    - ready=1.
    - On an edge with code_valid=1: capture code_in, state goes to GRANT, counter loads HOLD-1.
    - Accept latency is 1 cycle: grant appears in the cycle after the accepting edge.
  - GRANT:
    - grant = 1 << captured code, grant_valid=1, ready=0.
    - Each edge: if counter is 0, go to GAP with counter = GAP-1, or go straight to IDLE if GAP=0. Otherwise decrement the counter.
    - done = (state==GRANT) and (counter==0), so done is exactly one cycle wide.
  - GAP:
    - grant=0, grant_valid=0, ready=0.
    - Each edge: if counter is 0, go to IDLE; otherwise decrement.
- Minimum accept-to-accept period is HOLD+GAP+1 cycles.
- code_in is sampled only on the accepting edge. Changes during GRANT or GAP are ignored.
- drop_cnt increments by 1 on every edge where code_valid=1 and state is not IDLE. It saturates at all-ones and never wraps. It clears only on rst.
- Reset during GRANT or GAP: next edge goes to IDLE with grant=0. No done pulse is produced, and drop_cnt clears.
- rst has priority over acceptance on the same edge.
- code_valid=0 in IDLE: the block stays in IDLE and all outputs hold their idle values.

Decomposition:
- Package grant_decoder_pkg holds:
  - the state type (IDLE, GRANT, GAP) with fixed 2-bit encodings;
  - the localparam checks CODE_W == clog2(N_OUT), HOLD >= 1, GAP >= 0.
- One sub-module, onehot_dec: purely combinational CODE_W-to-N_OUT decoder, driven from the captured code register.
- The FSM, counters and drop_cnt stay in grant_decoder.

Test Plan:
All scenarios use defaults (N_OUT=4, HOLD=3, GAP=1) unless stated; k is the accepting edge.
1. rst=1 for 2 cycles with code_valid=1, code_in=3 -> grant=0000, grant_valid=0, done=0, drop_cnt=0 throughout; ready=1 in the first cycle after release.
2. code_in=2, code_valid pulsed high at edge k ->
   - grant=0100 and grant_valid=1 in cycles k+1..k+3;
   - done=1 only in k+3;
   - ready=0 in k+1..k+4, ready=1 in k+5;
   - drop_cnt stays 0.
3. code_valid held high, code_in=3 ->
   - grant=1000 bursts start at k+1, k+6, k+11 (period 5);
   - drop_cnt increases by 4 per period (reads 4 in cycle k+5, 8 in cycle k+10).
4. Accept code 0 at k, then code_in=1 with code_valid=1 from k+1 -> grant stays 0001 for k+1..k+3; next acceptance at k+5 yields 0010.
5. Accept code 2 at k, assert rst at edge k+2 -> grant=0000 from k+3, no done pulse, drop_cnt=0, ready=1 in k+3 after rst is released.
6. Two parameter variants:
   - GAP=0: accept at k -> grant k+1..k+3, ready=1 at k+4.
   - DROP_W=8: hold code_valid=1 for 400 cycles -> drop_cnt reaches 255 and stays 255.
